// File: rtl/cordic_engine_if.sv
// rtl/cordic_engine_if.sv - start/operand/result bundle between the QR controller and cordic_engine
interface cordic_engine_if;
   logic               enable;
   logic               select;
   logic signed [31:0] x_in;
   logic signed [31:0] y_in;
   logic signed [31:0] z_in;
   logic signed [31:0] x_out;
   logic signed [31:0] y_out;
   logic signed [31:0] z_out;
   logic               done;
   logic               busy;

   modport master (
      output enable, select, x_in, y_in, z_in,
      input  x_out, y_out, z_out, done, busy
   );

   modport slave (
      input  enable, select, x_in, y_in, z_in,
      output x_out, y_out, z_out, done, busy
   );
endinterface

// File: rtl/cordic_engine.sv
// rtl/cordic_engine.sv - iterative CORDIC, vectoring (select=1) or rotation (select=0)
// Define CORDIC_GAIN_COMP_EN to add the COMP state that removes the 1/K CORDIC gain.
module cordic_engine #(
   parameter int ITERATIONS = 16,
   parameter int FRAC       = 16
) (
   input  logic           clk,
   input  logic           rst,
   cordic_engine_if.slave bus
);
   localparam int CW = $clog2(ITERATIONS);
   localparam logic signed [31:0] HALF_PI     = 32'($rtoi(1.5707963267948966 * (2.0 ** FRAC) + 0.5));
   localparam logic signed [31:0] NEG_HALF_PI = -HALF_PI;

   function automatic logic [ITERATIONS*32-1:0] build_atan_lut();
      logic [ITERATIONS*32-1:0] lut;
      lut = '0;
      for (int i = 0; i < ITERATIONS; i++) begin
         lut[i*32 +: 32] = 32'($rtoi($atan(1.0 / (2.0 ** i)) * (2.0 ** FRAC) + 0.5));
      end
      return lut;
   endfunction

   localparam logic [ITERATIONS*32-1:0] ATAN_LUT = build_atan_lut();

   function automatic logic signed [31:0] sat32(input logic signed [33:0] v);
      if (v[33:31] == 3'b000 || v[33:31] == 3'b111) begin
         return v[31:0];
      end
      return v[33] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
   endfunction

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      ITER,
`ifdef CORDIC_GAIN_COMP_EN
      COMP,
`endif
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic signed [33:0] x_q, x_d;
   logic signed [33:0] y_q, y_d;
   logic signed [31:0] z_q, z_d;
   logic               mode_q, mode_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic signed [31:0] xo_q, xo_d;
   logic signed [31:0] yo_q, yo_d;
   logic signed [31:0] zo_q, zo_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;

   logic signed [33:0] x_shift, y_shift;
   logic signed [31:0] atan_i;
   logic               d_neg;

   assign x_shift = x_q >>> cnt_q;
   assign y_shift = y_q >>> cnt_q;
   assign atan_i  = ATAN_LUT[int'(cnt_q)*32 +: 32];
   // d = -1 drives y toward zero (vectoring) or z toward zero (rotation)
   assign d_neg   = mode_q ? !y_q[33] : z_q[31];

`ifdef CORDIC_GAIN_COMP_EN
   localparam logic signed [33:0] INV_K = 34'($rtoi(0.6072529350 * (2.0 ** FRAC) + 0.5));
   logic signed [67:0] x_prod, y_prod;
   assign x_prod = 68'(x_q) * 68'(INV_K);
   assign y_prod = 68'(y_q) * 68'(INV_K);
`endif

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      xo_d    = xo_q;
      yo_d    = yo_q;
      zo_d    = zo_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            // the cycle showing done is still the tail of the previous op
            if (bus.enable && !done_q) begin
               x_d     = {{2{bus.x_in[31]}}, bus.x_in};
               y_d     = {{2{bus.y_in[31]}}, bus.y_in};
               z_d     = bus.z_in;
               mode_d  = bus.select;
               cnt_d   = '0;
               state_d = PRE;
            end
         end
         PRE: begin
            if (mode_q) begin
               z_d = '0;
               if (x_q[33]) begin
                  if (!y_q[33]) begin
                     x_d = y_q;
                     y_d = -x_q;
                     z_d = HALF_PI;
                  end else begin
                     x_d = -y_q;
                     y_d = x_q;
                     z_d = NEG_HALF_PI;
                  end
               end
            end else if (z_q > HALF_PI) begin
               x_d = -y_q;
               y_d = x_q;
               z_d = z_q - HALF_PI;
            end else if (z_q < NEG_HALF_PI) begin
               x_d = y_q;
               y_d = -x_q;
               z_d = z_q + HALF_PI;
            end
            state_d = ITER;
         end
         ITER: begin
            if (d_neg) begin
               x_d = x_q + y_shift;
               y_d = y_q - x_shift;
               z_d = z_q + atan_i;
            end else begin
               x_d = x_q - y_shift;
               y_d = y_q + x_shift;
               z_d = z_q - atan_i;
            end
            cnt_d = CW'(cnt_q + 1'b1);
            if (cnt_q == CW'(ITERATIONS - 1)) begin
               cnt_d = '0;
`ifdef CORDIC_GAIN_COMP_EN
               state_d = COMP;
`else
               state_d = DONE;
`endif
            end
         end
`ifdef CORDIC_GAIN_COMP_EN
         COMP: begin
            x_d     = 34'(x_prod >>> FRAC);
            y_d     = 34'(y_prod >>> FRAC);
            state_d = DONE;
         end
`endif
         DONE: begin
            xo_d = sat32(x_q);
            if (mode_q) begin
               yo_d = z_q;
               zo_d = sat32(y_q);
            end else begin
               yo_d = sat32(y_q);
               zo_d = z_q;
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE) || done_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         mode_q  <= 1'b0;
         cnt_q   <= '0;
         xo_q    <= '0;
         yo_q    <= '0;
         zo_q    <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         xo_q    <= xo_d;
         yo_q    <= yo_d;
         zo_q    <= zo_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.x_out = xo_q;
   assign bus.y_out = yo_q;
   assign bus.z_out = zo_q;
   assign bus.done  = done_q;
   assign bus.busy  = busy_q;
endmodule

// File: tb/tb_cordic_engine.sv
// tb/tb_cordic_engine.sv - scoreboard bench for cordic_engine, directed vectors
// Expected magnitudes follow CORDIC_GAIN_COMP_EN (gain-corrected or carrying K).
module tb_cordic_engine;
`ifdef CORDIC_GAIN_COMP_EN
   localparam bit GAIN = 1'b1;
`else
   localparam bit GAIN = 1'b0;
`endif
   localparam int LAT   = GAIN ? 19 : 18;
   localparam int MAG5  = GAIN ? 327680 : 539610;
   localparam int MAG1  = GAIN ? 65536  : 107922;
   localparam int MAGR2 = GAIN ? 92682  : 152625;
   localparam int PI_Q  = 205887;
   localparam int HPI_Q = 102944;

   typedef struct {
      int id;
      int ex, ey, ez;
      int tx, ty, tz;
      int e_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   cordic_engine_if bus();

   cordic_engine #(.ITERATIONS(16), .FRAC(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int   cyc      = 0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   done_cnt = 0;
   exp_t sb[$];
   exp_t mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string what, input longint act, input longint req, input longint tol);
      longint d;
      n_checks++;
      d = act - req;
      if (d < 0) d = -d;
      if (d > tol) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (tol %0d)", what, act, req, tol);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && bus.done) begin
         done_cnt++;
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0, 0);
         end else begin
            mon_e = sb.pop_front();
            chk($sformatf("op%0d x_out", mon_e.id), bus.x_out, mon_e.ex, mon_e.tx);
            chk($sformatf("op%0d y_out", mon_e.id), bus.y_out, mon_e.ey, mon_e.ty);
            chk($sformatf("op%0d z_out", mon_e.id), bus.z_out, mon_e.ez, mon_e.tz);
            chk($sformatf("op%0d latency", mon_e.id), cyc - mon_e.e_cyc, LAT, 0);
            chk($sformatf("op%0d busy_at_done", mon_e.id), bus.busy, 1, 0);
         end
      end
   end

   task automatic drive(input bit sel, input int x, input int y, input int z);
      bus.enable = 1'b1;
      bus.select = sel;
      bus.x_in   = x;
      bus.y_in   = y;
      bus.z_in   = z;
   endtask

   task automatic issue(input int id, input bit push, input bit sel, input int x, input int y, input int z,
                        input int ex, input int ey, input int ez, input int tx, input int ty, input int tz);
      exp_t e;
      @(negedge clk);
      drive(sel, x, y, z);
      e.id = id; e.ex = ex; e.ey = ey; e.ez = ez;
      e.tx = tx; e.ty = ty; e.tz = tz;
      e.e_cyc = cyc + 1;
      if (push) sb.push_back(e);
      @(negedge clk);
      bus.enable = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus.busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("wait_idle busy", bus.busy, 0, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc;
      rst = 1'b1;
      bus.enable = 1'b0;
      bus.select = 1'b0;
      bus.x_in = 0; bus.y_in = 0; bus.z_in = 0;
      repeat (3) @(negedge clk);
      chk("reset x_out", bus.x_out, 0, 0);
      chk("reset y_out", bus.y_out, 0, 0);
      chk("reset z_out", bus.z_out, 0, 0);
      chk("reset done", bus.done, 0, 0);
      chk("reset busy", bus.busy, 0, 0);
      rst = 1'b0;

      issue(1, 1, 1'b1, 196608, 262144, 0, MAG5, 60771, 0, 16, 16, 64);           wait_idle();
      issue(2, 1, 1'b1, -65536, 0, 0, MAG1, PI_Q, 0, 16, 16, 64);                 wait_idle();
      issue(3, 1, 1'b1, -65536, -65536, 0, MAGR2, -154416, 0, 16, 16, 64);        wait_idle();
      issue(4, 1, 1'b0, 65536, 0, HPI_Q, 0, MAG1, 0, 16, 16, 16);                 wait_idle();
      issue(5, 1, 1'b0, 65536, 0, PI_Q, -MAG1, 0, 0, 16, 16, 16);                 wait_idle();
      issue(6, 1, 1'b0, 65536, 0, -PI_Q, -MAG1, 0, 0, 16, 16, 16);                wait_idle();
      issue(7, 1, 1'b0, 65536, 0, 0, MAG1, 0, 0, 16, 16, 16);                     wait_idle();
      issue(8, 1, 1'b1, 32'h7FFF0000, 32'h7FFF0000, 0, 32'h7FFFFFFF, 51472, 0, 0, 16, 200000);
      wait_idle();

      // second enable at E+5 must be dropped, not queued
      dc = done_cnt;
      issue(9, 1, 1'b1, 196608, 262144, 0, MAG5, 60771, 0, 16, 16, 64);
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         chk($sformatf("busy_hold k=%0d", k), bus.busy, 1, 0);
         if (k == 4) drive(1'b0, 65536, 0, HPI_Q);
         if (k == 5) bus.enable = 1'b0;
      end
      wait_idle();
      repeat (25) @(negedge clk);
      chk("busy_test done_count", done_cnt - dc, 1, 0);

      dc = done_cnt;
      issue(10, 0, 1'b1, 196608, 262144, 0, 0, 0, 0, 0, 0, 0);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("abort x_out", bus.x_out, 0, 0);
      chk("abort y_out", bus.y_out, 0, 0);
      chk("abort z_out", bus.z_out, 0, 0);
      chk("abort busy", bus.busy, 0, 0);
      repeat (25) @(negedge clk);
      chk("abort done_count", done_cnt - dc, 0, 0);

      issue(11, 1, 1'b0, 65536, 0, HPI_Q, 0, MAG1, 0, 16, 16, 16);
      wait_idle();
      repeat (3) @(negedge clk);

      chk("scoreboard_empty", sb.size(), 0, 0);
      chk("total_done_count", done_cnt, 10, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
